mips_multicycle_control: RTL and testbench

//  Main control unit for the multicycle MIPS core. Decodes opcode, sequences FETCH/DECODE/EXEC/MEM/WB
//  and drives every datapath select/enable. Also owns the request/ready handshake to the shared

---
 rtl/mips_multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: opcode decode, FSM sequencing,
// datapath selects/enables and the shared-memory request handshake.
//
// Ports:
//   clock, reset (async, active-low)
//   opcode       instruction[31:26] from the IR
//   mem_ready    memory finished the current read/write this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_src[1:0]   datapath controls (0 while in reset)
//   fault        sticky illegal-opcode / memory-timeout flag
module mips_multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       fault
);

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       fault;
  } ctl_t;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Counter only needs to reach MEM_WAIT_MAX-1: the wait that
  // would make it MEM_WAIT_MAX is the one that faults instead.
  localparam int unsigned CW =
    (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST =
    (MEM_WAIT_MAX == 0) ? '0 : CW'(MEM_WAIT_MAX - 1);

  logic [3:0]    state;
  logic [3:0]    nxt;
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          timeout;
  ctl_t          c;

  assign waiting = (state == S_FETCH) ||
                   (state == S_MEMRD) ||
                   (state == S_MEMWR);

  assign timeout = waiting && !mem_ready &&
                   (MEM_WAIT_MAX != 0) && (cnt == LAST);

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):   nxt = S_MEMADR;
          (opcode == OP_R):    nxt = S_EXEC;
          (opcode == OP_BEQ):  nxt = S_BRANCH;
          (opcode == OP_ADDI): nxt = S_ADDIEX;
          (opcode == OP_J):    nxt = S_JUMP;
          default:             nxt = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          (opcode == OP_LW): nxt = S_MEMRD;
          (opcode == OP_SW): nxt = S_MEMWR;
          default:           nxt = S_FAULT;
        endcase
      end
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
    if (timeout) nxt = S_FAULT;
  end

  // Counter idles at 0 outside a wait, so every wait state is
  // entered with a cleared count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (waiting && !mem_ready && !timeout && MEM_WAIT_MAX != 0)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
    end
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
  end

  // Gate everything with reset so enables drop the instant it asserts.
  assign {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
          alu_src_b, alu_op, pc_src, fault} = reset ? c : '0;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction phase model
// with randomized memory waits, checked cycle by cycle.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       fault;
  } outs_t;

  typedef enum {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_FAULT
  } ph_t;

  typedef struct {
    ph_t        ph;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       rdy;
  logic       rdy_w;
  outs_t      o;
  outs_t      ow;
  outs_t      e;
  int         checks;
  int         failures;
  step_t      seq[$];

  mips_multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(rdy),
    .pc_write(o.pc_write), .pc_write_cond(o.pc_write_cond),
    .i_or_d(o.i_or_d), .mem_read(o.mem_read),
    .mem_write(o.mem_write), .ir_write(o.ir_write),
    .mem_to_reg(o.mem_to_reg), .reg_dst(o.reg_dst),
    .reg_write(o.reg_write), .alu_src_a(o.alu_src_a),
    .alu_src_b(o.alu_src_b), .alu_op(o.alu_op),
    .pc_src(o.pc_src), .fault(o.fault)
  );

  mips_multicycle_control #(.MEM_WAIT_MAX(4)) dut_w (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(rdy_w),
    .pc_write(ow.pc_write), .pc_write_cond(ow.pc_write_cond),
    .i_or_d(ow.i_or_d), .mem_read(ow.mem_read),
    .mem_write(ow.mem_write), .ir_write(ow.ir_write),
    .mem_to_reg(ow.mem_to_reg), .reg_dst(ow.reg_dst),
    .reg_write(ow.reg_write), .alu_src_a(ow.alu_src_a),
    .alu_src_b(ow.alu_src_b), .alu_op(ow.alu_op),
    .pc_src(ow.pc_src), .fault(ow.fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic outs_t exp_out(ph_t ph, logic r);
    outs_t x = '0;
    case (ph)
      P_FETCH: begin
        x.mem_read = 1; x.alu_src_b = 2'b01;
        x.ir_write = r; x.pc_write = r;
      end
      P_DECODE: x.alu_src_b = 2'b11;
      P_MEMADR: begin x.alu_src_a = 1; x.alu_src_b = 2'b10; end
      P_MEMRD:  begin x.mem_read = 1; x.i_or_d = 1; end
      P_MEMWB:  begin x.reg_write = 1; x.mem_to_reg = 1; end
      P_MEMWR:  begin x.mem_write = 1; x.i_or_d = 1; end
      P_EXEC:   begin x.alu_src_a = 1; x.alu_op = 2'b10; end
      P_ALUWB:  begin x.reg_write = 1; x.reg_dst = 1; end
      P_BRANCH: begin
        x.alu_src_a = 1; x.alu_op = 2'b01;
        x.pc_write_cond = 1; x.pc_src = 2'b01;
      end
      P_ADDIEX: begin x.alu_src_a = 1; x.alu_src_b = 2'b10; end
      P_ADDIWB: x.reg_write = 1;
      P_JUMP:   begin x.pc_write = 1; x.pc_src = 2'b10; end
      P_FAULT:  x.fault = 1;
      default:  x = '0;
    endcase
    return x;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(ph_t ph, logic r, logic [5:0] op);
    step_t s;
    s.ph = ph; s.rdy = r; s.op = op;
    seq.push_back(s);
  endfunction

  // A memory phase: w not-ready cycles then ready, or a fault once
  // the wait budget lim is used up (lim==0: never).
  function automatic bit push_wait(ph_t ph, int w, int lim,
                                   logic [5:0] op);
    if (lim != 0 && w >= lim) begin
      repeat (lim) push(ph, 1'b0, op);
      repeat (3) push(P_FAULT, rnd(), op);
      return 1'b1;
    end
    repeat (w) push(ph, 1'b0, op);
    push(ph, 1'b1, op);
    return 1'b0;
  endfunction

  function automatic void build(logic [5:0] op, int fw, int mw,
                                int lim);
    if (push_wait(P_FETCH, fw, lim, op)) return;
    push(P_DECODE, rnd(), op);
    case (op)
      OP_LW: begin
        push(P_MEMADR, rnd(), op);
        if (!push_wait(P_MEMRD, mw, lim, op))
          push(P_MEMWB, rnd(), op);
      end
      OP_SW: begin
        push(P_MEMADR, rnd(), op);
        void'(push_wait(P_MEMWR, mw, lim, op));
      end
      OP_R: begin
        push(P_EXEC, rnd(), op);
        push(P_ALUWB, rnd(), op);
      end
      OP_BEQ:  push(P_BRANCH, rnd(), op);
      OP_ADDI: begin
        push(P_ADDIEX, rnd(), op);
        push(P_ADDIWB, rnd(), op);
      end
      OP_J:    push(P_JUMP, rnd(), op);
      default: repeat (22) push(P_FAULT, rnd(), op);
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b0; rdy = 1'b0; rdy_w = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rdy = 1'b1; rdy_w = 1'b1; opcode = OP_LW;
    #3;
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_main got=%h exp=0", o);
    end
    checks++;
    if (ow !== '0) begin
      failures++;
      $display("FAIL reset_w got=%h exp=0", ow);
    end
    @(negedge clock);
    do_reset();
  endtask

  task automatic test_lw();
    seq.delete();
    build(OP_LW, 0, 0, 15);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL lw step=%0d %s got=%h exp=%h",
                 i, seq[i].ph.name(), o, e);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sw_wait();
    seq.delete();
    build(OP_SW, 1, 3, 15);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sw_wait step=%0d %s got=%h exp=%h",
                 i, seq[i].ph.name(), o, e);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    seq.delete();
    build(OP_R, 0, 0, 15);
    build(OP_BEQ, 0, 0, 15);
    build(OP_J, 0, 0, 15);
    build(OP_ADDI, 2, 0, 15);
    build(OP_LW, 0, 2, 15);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b step=%0d %s got=%h exp=%h",
                 i, seq[i].ph.name(), o, e);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    seq.delete();
    build(OP_LW, 0, 5, 15);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL async_pre step=%0d %s got=%h exp=%h",
                 i, seq[i].ph.name(), o, e);
      end
      if (seq[i].ph == P_MEMRD) n++;
      if (n == 2) break;
      @(negedge clock);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL async_zero got=%h exp=0", o);
    end
    rdy = 1'b0; reset = 1'b1;
    #1;
    e = exp_out(P_FETCH, 1'b0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL async_fetch got=%h exp=%h", o, e);
    end
    @(negedge clock);
  endtask

  task automatic test_illegal();
    seq.delete();
    build(6'b111111, 0, 0, 15);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal step=%0d %s got=%h exp=%h",
                 i, seq[i].ph.name(), o, e);
      end
      @(negedge clock);
    end
    do_reset();
    seq.delete();
    push(P_FETCH, 1'b0, OP_J);
    push(P_FETCH, 1'b0, OP_J);
    foreach (seq[i]) begin
      opcode = seq[i].op; rdy = seq[i].rdy;
      #1;
      e = exp_out(seq[i].ph, seq[i].rdy);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal_recover step=%0d got=%h exp=%h",
                 i, o, e);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 3; k++) begin
      do_reset();
      seq.delete();
      case (k)
        0: build(OP_R, 4, 0, 4);
        1: begin
          build(OP_R, 3, 0, 4);
          build(OP_LW, 0, 4, 4);
        end
        default: build(OP_SW, 2, 3, 4);
      endcase
      foreach (seq[i]) begin
        opcode = seq[i].op; rdy_w = seq[i].rdy;
        #1;
        e = exp_out(seq[i].ph, seq[i].rdy);
        checks++;
        if (ow !== e) begin
          failures++;
          $display("FAIL timeout case=%0d step=%0d %s got=%h exp=%h",
                   k, i, seq[i].ph.name(), ow, e);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    int fw;
    int mw;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: op = 6'($urandom);
      endcase
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17)
                                       : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17)
                                       : $urandom_range(0, 3);
      seq.delete();
      build(op, fw, mw, 15);
      foreach (seq[i]) begin
        opcode = seq[i].op; rdy = seq[i].rdy;
        #1;
        e = exp_out(seq[i].ph, seq[i].rdy);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL rand n=%0d op=%b step=%0d %s got=%h exp=%h",
                   n, op, i, seq[i].ph.name(), o, e);
        end
        @(negedge clock);
      end
      if (seq[$].ph == P_FAULT) do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    rdy = 1'b0;
    rdy_w = 1'b0;
    opcode = '0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_async_reset();
    test_illegal();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
